// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU control FSM and mem_responder.
// The requester holds req until ack; rdata/err are valid with ack.
interface mem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;
   logic              busy;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack, err, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack, err, busy
   );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: req/ack front end for a synchronous block RAM.
// Optional switch/LED I/O window enabled by MEM_RESPONDER_IO_EN.
module mem_responder #(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 16,
   parameter int                WAIT_STATES = 0,
   parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(16'hFF00)
) (
   input  logic              clk,
   input  logic              rst,
   mem_responder_if.slave    bus,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic [9:0]        sw_in,
   output logic [9:0]        led_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t            r_state;
   logic [3:0]        r_wait;
   logic              r_store;
   logic              r_is_io;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_din;
   logic              r_ram_we;
   logic              r_ack;
   logic              r_err;
   logic              r_rd_ram;
   logic [DATA_W-1:0] r_rdata;

   logic              w_done;
   logic              w_io_hit;
   logic              w_io_err;
   logic [DATA_W-1:0] w_io_rdata;

   assign w_done = (r_state == S_ACCESS) &&
                   (r_wait == 4'(WAIT_STATES));

`ifdef MEM_RESPONDER_IO_EN
   localparam logic [ADDR_W-1:0] IO_LED = IO_BASE + ADDR_W'(1);

   logic [9:0] r_sw1;
   logic [9:0] r_sw2;
   logic [9:0] r_led;

   always_comb begin
      w_io_hit   = bus.addr >= IO_BASE;
      w_io_err   = r_is_io &&
                   (r_ram_addr != IO_BASE) &&
                   (r_ram_addr != IO_LED);
      w_io_rdata = '0;
      if (r_ram_addr == IO_BASE)
         w_io_rdata[9:0] = r_sw2;
      else if (r_ram_addr == IO_LED)
         w_io_rdata[9:0] = r_led;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sw1 <= '0;
         r_sw2 <= '0;
         r_led <= '0;
      end else begin
         r_sw1 <= sw_in;
         r_sw2 <= r_sw1;
         if (w_done && r_is_io && r_store &&
             (r_ram_addr == IO_LED))
            r_led <= r_ram_din[9:0];
      end
   end

   assign led_out = r_led;
`else
   logic w_unused;

   assign w_io_hit   = 1'b0;
   assign w_io_err   = 1'b0;
   assign w_io_rdata = '0;
   assign led_out    = '0;
   assign w_unused   = ^{sw_in, IO_BASE};
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_wait     <= '0;
         r_store    <= 1'b0;
         r_is_io    <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
         r_ram_we   <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_rd_ram   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_ram_we <= 1'b0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_rd_ram <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_ram_addr <= bus.addr;
                  r_ram_din  <= bus.wdata;
                  r_store    <= bus.we;
                  r_is_io    <= w_io_hit;
                  r_ram_we   <= bus.we && !w_io_hit;
                  r_wait     <= '0;
                  r_state    <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (w_done) begin
                  r_state  <= S_RESP;
                  r_ack    <= 1'b1;
                  r_err    <= w_io_err;
                  r_rd_ram <= !r_store && !r_is_io;
                  if (!r_store && r_is_io)
                     r_rdata <= w_io_rdata;
               end else begin
                  r_wait <= r_wait + 4'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               if (r_rd_ram)
                  r_rdata <= ram_dout;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // RAM data shows through during RESP, then is held in r_rdata
   assign bus.rdata = r_rd_ram ? ram_dout : r_rdata;
   assign bus.ack   = r_ack;
   assign bus.err   = r_err;
   assign bus.busy  = r_state != S_IDLE;

   // a reset landing on the write cycle must not reach the RAM
   assign ram_we   = r_ram_we && rst;
   assign ram_addr = r_ram_addr;
   assign ram_din  = r_ram_din;

endmodule
